// File: rtl/circularfifo_param.sv
// circularfifo_param: parametrised single-clock circular FIFO with occupancy, level flags, sticky errors and flush
module circularfifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                      processor_clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     datainput,
  input  logic                      pop,
  output logic [DATA_WIDTH-1:0]     dataoutput,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] AF  = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE  = (AW+1)'(AE_LEVEL);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_w_ptr, r_r_ptr, w_count;
  logic w_pop_ok, w_push_ok;
  assign w_count      = r_w_ptr - r_r_ptr;
  assign empty        = r_w_ptr == r_r_ptr;
  assign full         = (r_w_ptr[AW-1:0] == r_r_ptr[AW-1:0]) && (r_w_ptr[AW] != r_r_ptr[AW]);
  assign count        = w_count;
  assign almost_full  = w_count >= AF;
  assign almost_empty = w_count <= AE;
  // flush swallows any push/pop in its cycle, so neither is accepted
  assign w_pop_ok     = pop & ~empty & ~flush;
  assign w_push_ok    = push & ~flush & (~full | w_pop_ok);
  always_ff @(posedge processor_clk)
    if (w_push_ok) r_mem[r_w_ptr[AW-1:0]] <= datainput;
  always_ff @(posedge processor_clk or posedge reset) begin
    if (reset) begin
      r_w_ptr    <= '0;
      r_r_ptr    <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      dataoutput <= '0;
    end else if (flush) begin
      r_w_ptr    <= '0;
      r_r_ptr    <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      dataoutput <= '0;
    end else begin
      if (w_push_ok) r_w_ptr <= r_w_ptr + ONE;
      if (w_pop_ok) begin
        r_r_ptr    <= r_r_ptr + ONE;
        dataoutput <= r_mem[r_r_ptr[AW-1:0]];
      end
      if (push & ~w_push_ok) overflow <= 1'b1;
      if (pop & empty) underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_circularfifo_param.sv
// tb_circularfifo_param: scoreboard bench for circularfifo_param at DEPTH=16
module tb_circularfifo_param;
  logic clk = 1'b0, rst, fl, pu, po;
  logic [7:0] din, dout;
  logic full, empty, af, ae, ovf, udf;
  logic [4:0] cnt;
  int errors = 0, checks = 0;
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic m_ovf, m_udf;
  circularfifo_param #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .processor_clk(clk), .reset(rst), .flush(fl), .push(pu), .datainput(din), .pop(po),
    .dataoutput(dout), .full(full), .empty(empty), .almost_full(af), .almost_empty(ae),
    .count(cnt), .overflow(ovf), .underflow(udf));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_state(input string tag);
    int n = q.size();
    chk({tag, ":count"}, 32'(cnt), 32'(n));
    chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ":full"}, 32'(full), 32'(n == 16));
    chk({tag, ":af"}, 32'(af), 32'(n >= 14));
    chk({tag, ":ae"}, 32'(ae), 32'(n <= 2));
    chk({tag, ":ovf"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ":udf"}, 32'(udf), 32'(m_udf));
    chk({tag, ":dout"}, 32'(dout), 32'(m_dout));
  endtask
  task automatic model_reset();
    q.delete();
    m_dout = 8'h00;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask
  task automatic cyc(input string tag, input logic p, input logic [7:0] d, input logic r, input logic f);
    logic pop_ok, push_ok;
    pu = p; din = d; po = r; fl = f;
    @(posedge clk); #1;
    pu = 0; po = 0; fl = 0;
    if (f) model_reset();
    else begin
      pop_ok  = r && q.size() != 0;
      push_ok = p && (q.size() != 16 || pop_ok);
      if (r && q.size() == 0) m_udf = 1'b1;
      if (p && !push_ok) m_ovf = 1'b1;
      if (pop_ok) m_dout = q.pop_front();
      if (push_ok) q.push_back(d);
    end
    chk_state(tag);
  endtask
  initial begin
    rst = 1; fl = 0; pu = 0; po = 0; din = 0;
    model_reset();
    #12;
    chk_state("reset");
    rst = 0;
    cyc("push11", 1, 8'h11, 0, 0);
    cyc("push22", 1, 8'h22, 0, 0);
    cyc("push33", 1, 8'h33, 0, 0);
    for (int i = 0; i < 3; i++) cyc("pop3", 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) cyc("fill", 1, 8'h40 + 8'(i), 0, 0);
    cyc("overfl", 1, 8'hEE, 0, 0);
    cyc("fullpp", 1, 8'hAA, 1, 0);
    for (int i = 0; i < 16; i++) cyc("drain", 0, 0, 1, 0);
    chk("aa_last", 32'(dout), 32'hAA);
    cyc("udfpop", 0, 0, 1, 0);
    cyc("emptypp", 1, 8'h5C, 1, 0);
    for (int i = 0; i < 4; i++) cyc("to5", 1, 8'h60 + 8'(i), 0, 0);
    chk("cnt5", 32'(cnt), 32'd5);
    cyc("flush", 1, 8'h99, 0, 1);
    chk("flush_dout", 32'(dout), 32'h0);
    cyc("wrap0", 1, 8'h00, 0, 0);
    for (int i = 1; i <= 40; i++) cyc("wrap", 1, 8'(i), 1, 0);
    cyc("wrapend", 0, 0, 1, 0);
    chk("wrap_last", 32'(dout), 32'd40);
    for (int i = 0; i < 5; i++) cyc("burst", 1, 8'hB0 + 8'(i), i > 2, 0);
    #3 rst = 1;
    #1 model_reset();
    chk_state("midrst");
    #2 rst = 0;
    cyc("postrst", 1, 8'h7E, 0, 0);
    cyc("postpop", 0, 0, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/circularfifo_param.md
# circularfifo_param

Parametrised single-clock circular FIFO, the successor of the fixed-size circular FIFO used between the UART and processor paths. It adds configurable data width and depth, an occupancy count, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, and a synchronous flush. It sits between a producer (UART receive path) and a consumer (processor) that share one clock domain. Storage is an internal dual-port register array addressed by wrap-bit read and write pointers.

## Interface

Parameters:
- DATA_WIDTH, 8, width of datainput and dataoutput
- DEPTH, 16, number of entries; power of 2, at least 2
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1

Ports:
- processor_clk, input, 1, sole clock; all state updates on its rising edge
- reset, input, 1, asynchronous, active-high reset
- flush, input, 1, synchronous clear of FIFO contents and error flags
- push, input, 1, write request
- datainput, input, DATA_WIDTH, write data, sampled when push is accepted
- pop, input, 1, read request
- dataoutput, output, DATA_WIDTH, registered read data
- full, output, 1, count == DEPTH
- empty, output, 1, count == 0
- almost_full, output, 1, count >= AF_LEVEL
- almost_empty, output, 1, count <= AE_LEVEL
- count, output, $clog2(DEPTH)+1, current occupancy
- overflow, output, 1, sticky; set when a push is rejected
- underflow, output, 1, sticky; set when a pop is rejected

## Operation

- Pointers are w_ptr and r_ptr, each $clog2(DEPTH)+1 bits. The low bits address the array. The MSB is a wrap bit, and pointers wrap naturally modulo 2*DEPTH.
- The status flags are derived from the pointers:
  - empty when w_ptr == r_ptr.
  - full when the address bits are equal and the MSBs differ.
  - count = w_ptr - r_ptr, computed modulo 2^($clog2(DEPTH)+1).
- Acceptance is evaluated on pre-edge state:
  - pop_ok = pop & !empty.
  - push_ok = push & (!full | pop_ok).
- On push_ok, datainput is written at mem[w_ptr low bits] and w_ptr increments.
- On pop_ok, dataoutput is loaded with mem[r_ptr low bits] and r_ptr increments. Otherwise dataoutput holds its value.
- Simultaneous push and pop:
  - When empty: push accepted, pop rejected, underflow set; the written data is not bypassed to dataoutput.
  - When full: both accepted, count unchanged.
  - Otherwise: both accepted, count unchanged.
- Error flags:
  - overflow is set by push & !push_ok.
  - underflow is set by pop & empty.
  - Both flags stay set until flush or reset.
- flush has priority over push and pop in the same cycle. It clears w_ptr, r_ptr, overflow, underflow and dataoutput to 0. Array contents are not cleared.
- flush is not accepted as a data operation: a push or pop presented in the flush cycle is discarded and does not set any error flag.

## Timing

- Reset (asynchronous, active-high) values:
  - w_ptr = r_ptr = 0, count = 0.
  - empty = 1, full = 0, almost_full = 0 (AF_LEVEL >= 1), almost_empty = 1.
  - overflow = underflow = 0, dataoutput = 0.
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge. All queued data is lost.
- The first push is possible on the first rising edge after reset deasserts.
- Write to read latency:
  - A word pushed at edge N is poppable from edge N+1 (empty deasserts after edge N).
  - dataoutput is valid after the pop edge, i.e. one cycle of read latency.
- All flags and count are registered-state functions and update after the accepting edge. No combinational path runs from push or pop to any flag.

## Test plan

- Reset, then push 0x11, 0x22, 0x33, then pop three times -> dataoutput 0x11, 0x22, 0x33 on successive edges; count goes 3, 2, 1, 0; empty = 1 at the end.
- With DEPTH = 16, push 16 words -> full = 1, count = 16, almost_full from count 14. A 17th push is rejected: overflow = 1 and count stays 16.
- With the FIFO full, push 0xAA and pop together -> both accepted, count stays 16, dataoutput is the oldest word. 0xAA is read last after draining.
- Pop when empty -> underflow = 1 and dataoutput unchanged. Push and pop together when empty -> count = 1, underflow = 1.
- Wrap-around: run 40 push/pop pairs with an incrementing pattern through DEPTH = 16 -> data is in order, no flags set, and the pointer MSB toggles correctly.
- Flush with count = 5 and overflow = 1, with push asserted in the same cycle -> count = 0, empty = 1, overflow = 0, dataoutput = 0. The push is discarded. Separately, assert reset between edges mid-burst -> outputs reach their reset values immediately.
